verilog_multiplier: RTL and testbench
=====================================

VERILOG_MULTIPLIER -- requirements
Module: verilog_multiplier

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; P width is 2*WIDTH; all Verification values use WIDTH=32.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low (rst=0 resets, rst=1 runs).
REQ-004 Port: A  input  WIDTH  signed two's-complement multiplicand.
REQ-005 Port: B  input  WIDTH  signed two's-complement multiplier.
REQ-006 Port: P  output  2*WIDTH  signed two's-complement product, driven directly from a register.

Function
REQ-007 The block SHALL be a two-stage pipeline: stage 1 registers A and B (A_r, B_r); stage 2 registers P <= A_r * B_r.
REQ-008 Latency SHALL be exactly 2 rising edges: operands present at edge N appear on P after edge N+1 and hold until after edge N+2.
REQ-009 Throughput SHALL be one new operand pair per cycle, with no stall, valid or handshake signals.
REQ-010 The product SHALL be the exact signed product, full width 2*WIDTH, with no truncation, rounding or saturation.
REQ-011 Boundary: (-2^31)*(-2^31) SHALL give +2^62.
REQ-012 Boundary: (-2^31)*(2^31-1) SHALL give -2^62+2^31.
REQ-013 Boundary: any operand equal to 0 SHALL give P=0.
REQ-014 Boundary: a multiplication by 1 SHALL pass the other operand through, sign-extended.
REQ-015 The combinational multiply between stages SHALL use radix-4 (modified) Booth recoding of B: WIDTH/2 partial products, each selecting 0, +A, +2A, -A or -2A.
REQ-016 Each partial product SHALL be sign-extended to 2*WIDTH and weighted by 4^i.
REQ-017 Negation of A SHALL be done as inversion plus a +1 correction bit injected into the reduction.
REQ-018 Partial products SHALL be reduced by a carry-save (3:2 compressor) tree to two vectors.
REQ-019 The two carry-save vectors SHALL be summed by one final 2*WIDTH-bit carry-propagate adder; the language multiply operator SHALL NOT be used.
REQ-020 The design SHALL contain no latches and no combinational path from A or B to P.
REQ-021 Inputs SHALL be treated as don't-care only while rst=0; X on the inputs during reset SHALL NOT corrupt the post-reset state.

Reset
REQ-022 While rst=0, A_r, B_r and P SHALL be 0 immediately, independent of clk.
REQ-023 On release of rst (0->1), the first operands SHALL be captured at the next rising edge and reach P one edge later; until then P SHALL stay 0.
REQ-024 Asserting rst mid-stream SHALL discard all in-flight operands; no pre-reset product SHALL appear on P after release.

Verification
REQ-025 Release rst; apply A=10,B=-150 for one cycle, then A=10,B=10 -> P=-1500 after the second edge following the first apply, then P=100 one cycle later.
REQ-026 Streaming pairs (-10,-150),(-150,150),(0,150),(1,150),(10,22),(2,4) on consecutive cycles -> P sequence 1500,-22500,0,150,220,8, one per cycle, each 2 edges after its input.
REQ-027 Corner operands (-2^31,-2^31),(-2^31,2^31-1),(2^31-1,2^31-1),(-1,-1) -> 2^62, -2^62+2^31, 2^62-2^32+1, 1.
REQ-028 Assert rst asynchronously between edges while the pipeline holds nonzero data -> P=0 at once; after release P stays 0 for one edge, then shows the first post-reset product.
REQ-029 10,000 random signed operand pairs plus all-ones and all-zeros patterns -> P matches a 64-bit signed reference model at 2-cycle latency every cycle.

Source files
------------

// File: rtl/verilog_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : verilog_multiplier
//  Description : Two-stage pipelined signed multiplier. Stage 1 registers the
//                operands; stage 2 registers the product formed by radix-4
//                Booth recoding, a carry-save 3:2 compressor tree and one
//                final carry-propagate adder.
//  Revision    : 1.0  initial release
// ============================================================================
module verilog_multiplier #(
  parameter int WIDTH = 32   // operand width, even and at least 4
) (
  input  logic                       clk,
  input  logic                       rst,   // asynchronous, active-low
  input  logic signed [WIDTH-1:0]    A,
  input  logic signed [WIDTH-1:0]    B,
  output logic signed [2*WIDTH-1:0]  P
);

  localparam int PW    = 2 * WIDTH;     // product width
  localparam int HALF  = WIDTH / 2;     // number of Booth partial products
  localparam int NROWS = HALF + 1;      // partial products plus correction row

  // Rows remaining after a given number of 3:2 reduction levels.
  function automatic int rows_at(input int lvl);
    int n;
    n = NROWS;
    for (int k = 0; k < lvl; k++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // Number of 3:2 levels needed to bring the rows down to two.
  function automatic int num_levels();
    int n;
    int l;
    n = NROWS;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  // Starting index of a level inside the flat row store.
  function automatic int offset(input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++) begin
      s = s + rows_at(k);
    end
    return s;
  endfunction

  localparam int LEVELS = num_levels();
  localparam int TOTAL  = offset(LEVELS) + 2;

  // Stage-1 operand registers
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  // All reduction rows, level after level; the last two are the carry-save pair
  logic [PW-1:0]    tree [0:TOTAL-1];

  // Per partial product negate flags and the +1 correction row built from them
  logic [HALF-1:0]  neg;
  logic [PW-1:0]    corr;

  // Booth triplets look at b[2i+1], b[2i], b[2i-1] with an implicit zero below bit 0
  logic [WIDTH:0]   b_ext;
  logic [PW-1:0]    sum_full;

  assign b_ext = {b_r, 1'b0};

  // Stage 1: capture operands; reset clears them so X inputs during reset are harmless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= A;
      b_r <= B;
    end
  end

  // --------------------------------------------------------------------------
  // Booth radix-4 partial products. Each row is the selected multiple of A
  // (0, A or 2A), sign-extended to the product width, inverted when the digit
  // is negative, then weighted by 4^i. The +1 that completes a two's-complement
  // negation is not added here; it is collected in the correction row.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < HALF; i++) begin : g_pp
      logic [2:0]       trip;
      logic             sel1;
      logic             sel2;
      logic [WIDTH:0]   mag;
      logic [PW-1:0]    ext;
      logic [PW-1:0]    inv;

      assign trip = b_ext[2*i+2 -: 3];
      // +/-A for digits 001, 010, 101, 110
      assign sel1 = trip[0] ^ trip[1];
      // +/-2A for digits 011 and 100
      assign sel2 = (trip == 3'b011) || (trip == 3'b100);
      // digit is negative unless it is the zero code 111
      assign neg[i] = trip[2] & ~(trip[1] & trip[0]);

      assign mag = sel1 ? {a_r[WIDTH-1], a_r} :
                   sel2 ? {a_r, 1'b0}         :
                          '0;
      assign ext = {{(WIDTH-1){mag[WIDTH]}}, mag};
      assign inv = neg[i] ? ~ext : ext;

      assign tree[i] = inv << (2 * i);
    end

    // Correction row: bit 2i carries the +1 for a negated partial product i
    for (genvar j = 0; j < PW; j++) begin : g_corr
      if ((j % 2 == 0) && (j / 2 < HALF)) begin : g_bit
        assign corr[j] = neg[j/2];
      end else begin : g_zero
        assign corr[j] = 1'b0;
      end
    end
  endgenerate

  assign tree[HALF] = corr;

  // --------------------------------------------------------------------------
  // Carry-save reduction. Each level groups its rows in threes and replaces
  // every group by a sum and a carry row; leftover rows pass straight through.
  // The carry leaving the top bit is dropped, which is exact modulo 2^PW.
  // --------------------------------------------------------------------------
  generate
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
      localparam int N   = rows_at(l);
      localparam int G   = N / 3;
      localparam int IN  = offset(l);
      localparam int OUT = offset(l + 1);

      for (genvar g = 0; g < G; g++) begin : g_csa
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [PW-1:0] z;

        assign x = tree[IN + 3*g];
        assign y = tree[IN + 3*g + 1];
        assign z = tree[IN + 3*g + 2];

        assign tree[OUT + 2*g]     = x ^ y ^ z;
        assign tree[OUT + 2*g + 1] = {(x[PW-2:0] & y[PW-2:0]) |
                                      (x[PW-2:0] & z[PW-2:0]) |
                                      (y[PW-2:0] & z[PW-2:0]), 1'b0};
      end

      for (genvar r = 0; r < N % 3; r++) begin : g_pass
        assign tree[OUT + 2*G + r] = tree[IN + 3*G + r];
      end
    end
  endgenerate

  // Single carry-propagate adder merges the carry-save pair
  assign sum_full = tree[TOTAL-2] + tree[TOTAL-1];

  // Stage 2: register the product so P comes straight from a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P <= '0;
    end else begin
      P <= sum_full;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_verilog_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_verilog_multiplier
//  Description : Directed and random checks of the two-stage signed multiplier
//                at WIDTH=32 with a 2-edge latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_verilog_multiplier;

  logic               clk;
  logic               rst;
  logic signed [31:0] A;
  logic signed [31:0] B;
  logic signed [63:0] P;

  int n_cmp  = 0;
  int n_fail = 0;

  verilog_multiplier #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .P   (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset behaviour with X inputs, then the first two post-release products
  task automatic test_reset();
    rst = 1'b0;
    A   = 'x;
    B   = 'x;
    #1;
    n_cmp++;
    if (P !== 64'sd0) begin
      n_fail++;
      $display("FAIL reset_immediate: P=%0d expected 0", P);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (P !== 64'sd0) begin
      n_fail++;
      $display("FAIL reset_held_x_inputs: P=%0d expected 0", P);
    end
    rst = 1'b1;
    A   = 32'sd10;
    B   = -32'sd150;
    @(posedge clk); #1;
    n_cmp++;
    if (P !== 64'sd0) begin
      n_fail++;
      $display("FAIL release_first_edge: P=%0d expected 0", P);
    end
    A = 32'sd10;
    B = 32'sd10;
    @(posedge clk); #1;
    n_cmp++;
    if (P !== -64'sd1500) begin
      n_fail++;
      $display("FAIL basic_10x-150: P=%0d expected -1500", P);
    end
    A = 32'sd0;
    B = 32'sd0;
    @(posedge clk); #1;
    n_cmp++;
    if (P !== 64'sd100) begin
      n_fail++;
      $display("FAIL basic_10x10: P=%0d expected 100", P);
    end
  endtask

  // Back-to-back small signed pairs, one result per cycle
  task automatic test_back_to_back();
    logic signed [31:0] va [6];
    logic signed [31:0] vb [6];
    logic signed [63:0] ve [6];
    va = '{-32'sd10, -32'sd150, 32'sd0, 32'sd1, 32'sd10, 32'sd2};
    vb = '{-32'sd150, 32'sd150, 32'sd150, 32'sd150, 32'sd22, 32'sd4};
    ve = '{64'sd1500, -64'sd22500, 64'sd0, 64'sd150, 64'sd220, 64'sd8};
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        A = va[k];
        B = vb[k];
      end else begin
        A = 32'sd0;
        B = 32'sd0;
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        n_cmp++;
        if (P !== ve[k-1]) begin
          n_fail++;
          $display("FAIL stream[%0d]: P=%0d expected %0d", k-1, P, ve[k-1]);
        end
      end
    end
  endtask

  // Extreme operands and the zero / unit boundaries
  task automatic test_corners();
    logic signed [31:0] va [10];
    logic signed [31:0] vb [10];
    logic signed [63:0] ve [10];
    va = '{32'sh8000_0000, 32'sh8000_0000, 32'sh7FFF_FFFF, 32'shFFFF_FFFF,
           32'sd0, 32'shFFFF_FFFF, 32'sd1, 32'sh8000_0000, 32'sd12345, 32'sd0};
    vb = '{32'sh8000_0000, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'shFFFF_FFFF,
           32'shFFFF_FFFF, 32'sd0, 32'sh8000_0000, 32'sd1, 32'sd1, 32'sd0};
    ve = '{64'sh4000_0000_0000_0000, 64'shC000_0000_8000_0000,
           64'sh3FFF_FFFF_0000_0001, 64'sd1,
           64'sd0, 64'sd0,
           64'shFFFF_FFFF_8000_0000, 64'shFFFF_FFFF_8000_0000,
           64'sd12345, 64'sd0};
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        A = va[k];
        B = vb[k];
      end else begin
        A = 32'sd0;
        B = 32'sd0;
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        n_cmp++;
        if (P !== ve[k-1]) begin
          n_fail++;
          $display("FAIL corner[%0d]: P=%0h expected %0h", k-1, P, ve[k-1]);
        end
      end
    end
  endtask

  // Mid-cycle reset must flush the pipeline and the first post-release result
  task automatic test_async_reset();
    A = 32'sd5;
    B = 32'sd7;
    @(posedge clk); #1;
    A = 32'sd9;
    B = 32'sd9;
    @(posedge clk); #1;
    n_cmp++;
    if (P !== 64'sd35) begin
      n_fail++;
      $display("FAIL pre_reset_product: P=%0d expected 35", P);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (P !== 64'sd0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: P=%0d expected 0", P);
    end
    A = 32'sd123;
    B = 32'sd456;
    @(posedge clk); #1;
    n_cmp++;
    if (P !== 64'sd0) begin
      n_fail++;
      $display("FAIL async_reset_held: P=%0d expected 0", P);
    end
    rst = 1'b1;
    A   = 32'sd3;
    B   = 32'sd7;
    @(posedge clk); #1;
    n_cmp++;
    if (P !== 64'sd0) begin
      n_fail++;
      $display("FAIL post_release_flush: P=%0d expected 0", P);
    end
    A = 32'sd0;
    B = 32'sd0;
    @(posedge clk); #1;
    n_cmp++;
    if (P !== 64'sd21) begin
      n_fail++;
      $display("FAIL post_release_first: P=%0d expected 21", P);
    end
  endtask

  // Random signed pairs against a 64-bit signed reference at 2-cycle latency
  task automatic test_random(input int n);
    longint ea;
    longint eb;
    longint exp_prev;
    exp_prev = 0;
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        A = $signed($urandom);
        B = $signed($urandom);
      end else begin
        A = 32'sd0;
        B = 32'sd0;
      end
      ea = longint'(A);
      eb = longint'(B);
      @(posedge clk); #1;
      if (k >= 1) begin
        n_cmp++;
        if (P !== exp_prev) begin
          n_fail++;
          $display("FAIL random[%0d]: P=%0d expected %0d", k-1, P, exp_prev);
        end
      end
      exp_prev = ea * eb;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_corners();
    test_async_reset();
    test_random(10000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
